// File: rtl/interconn_rx.sv
// Receive-side landing engine for one crossbar port: lands each delivered word
// into local MVU memory at base+count and pulses done after the programmed length.
module interconn_rx #(
  parameter int W  = 128,
  parameter int AW = 12,
  parameter int LW = 13
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          cfg_start,
  input  logic [AW-1:0] cfg_base,
  input  logic [LW-1:0] cfg_len,
  input  logic          recv_en,
  input  logic [W-1:0]  recv_word,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [W-1:0]  mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err_unexp
);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t          state;
  logic [AW-1:0]   base_p0;
  logic [LW-1:0]   len_p0;
  logic [LW-1:0]   cnt_p0;
  logic [LW-1:0]   cnt_nxt;
  logic            vld_p1;
  logic [AW-1:0]   addr_p1;
  logic [W-1:0]    data_p1;
  logic            busy_p1;
  logic            done_p1;
  logic            err_p1;

  assign cnt_nxt = cnt_p0 + LW'(1);

  // stage p0 -> p1: accept a crossbar word and register the memory write
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      base_p0 <= '0;
      len_p0  <= '0;
      cnt_p0  <= '0;
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
      busy_p1 <= 1'b0;
      done_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            err_p1 <= 1'b0;
            if (cfg_len != '0) begin
              base_p0 <= cfg_base;
              len_p0  <= cfg_len;
              cnt_p0  <= '0;
              state   <= ARMED;
              busy_p1 <= 1'b1;
            end else begin
              done_p1 <= 1'b1;
            end
          end
          // Placed after the clear so a same-cycle stray word wins.
          if (recv_en) begin
            err_p1 <= 1'b1;
          end
        end
        ARMED: begin
          if (recv_en) begin
            vld_p1  <= 1'b1;
            addr_p1 <= base_p0 + cnt_p0[AW-1:0];
            data_p1 <= recv_word;
            cnt_p0  <= cnt_nxt;
            if (cnt_nxt == len_p0) begin
              state   <= IDLE;
              busy_p1 <= 1'b0;
              done_p1 <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_we    = vld_p1;
  assign mem_addr  = addr_p1;
  assign mem_wdata = data_p1;
  assign busy      = busy_p1;
  assign done      = done_p1;
  assign err_unexp = err_p1;

endmodule

// File: tb/tb_interconn_rx.sv
// Scoreboard bench for interconn_rx: a transaction-level model queues the
// expected write/done events, and a monitor compares them as the DUT emits them.
module tb_interconn_rx;
  localparam int W  = 128;
  localparam int AW = 12;
  localparam int LW = 13;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          recv_en = 1'b0;
  logic [W-1:0]  recv_word = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic          busy;
  logic          done;
  logic          err_unexp;

  interconn_rx #(.W(W), .AW(AW), .LW(LW)) dut (
    .clk(clk), .clr(clr), .cfg_start(cfg_start), .cfg_base(cfg_base),
    .cfg_len(cfg_len), .recv_en(recv_en), .recv_word(recv_word),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    bit           we;
    bit           dn;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;

  // Transfer-level reference state
  bit            m_armed = 1'b0;
  bit            m_err = 1'b0;
  int            m_base = 0;
  int            m_len = 0;
  int            m_cnt = 0;
  logic [AW-1:0] last_addr = '0;
  logic [W-1:0]  last_data = '0;

  bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Predict what the DUT shows after the coming clock edge from the current inputs.
  task automatic model();
    ev_t e;
    e.cyc  = cyc + 1;
    e.we   = 1'b0;
    e.dn   = 1'b0;
    e.addr = last_addr;
    e.data = last_data;
    if (!m_armed) begin
      if (cfg_start) begin
        m_err = 1'b0;
        if (cfg_len != 0) begin
          m_armed = 1'b1;
          m_base  = int'(cfg_base);
          m_len   = int'(cfg_len);
          m_cnt   = 0;
        end else begin
          e.dn = 1'b1;
        end
      end
      if (recv_en) m_err = 1'b1;
    end else if (recv_en) begin
      e.we      = 1'b1;
      e.addr    = AW'((m_base + m_cnt) % (1 << AW));
      e.data    = recv_word;
      last_addr = e.addr;
      last_data = e.data;
      m_cnt++;
      if (m_cnt == m_len) begin
        m_armed = 1'b0;
        e.dn    = 1'b1;
      end
    end
    if (e.we || e.dn) q.push_back(e);
  endtask

  task automatic step(input logic s, input logic [AW-1:0] b, input logic [LW-1:0] l,
                      input logic en, input logic [W-1:0] w);
    @(negedge clk);
    cfg_start = s;
    cfg_base  = b;
    cfg_len   = l;
    recv_en   = en;
    recv_word = w;
    model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    cfg_start = 1'b0;
    recv_en   = 1'b0;
    clr       = 1'b1;
    m_armed   = 1'b0;
    m_err     = 1'b0;
    last_addr = '0;
    last_data = '0;
    q.delete();
    #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_unexp, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    @(negedge clk);
    clr = 1'b0;
    model();
  endtask

  function automatic logic [W-1:0] rw();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Monitor: every cycle, match DUT output against the head of the event queue.
  always @(posedge clk) begin
    ev_t e;
    #1;
    if (!clr) begin
      chk("busy", busy, m_armed);
      chk("err_unexp", err_unexp, m_err);
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("mem_we", mem_we, e.we);
        chk("done", done, e.dn);
      end else begin
        chk("mem_we_spurious", mem_we, 0);
        chk("done_spurious", done, 0);
      end
      chk("mem_addr", mem_addr, last_addr);
      chk("mem_wdata", mem_wdata, last_data);
    end
  end

  initial begin
    do_reset();
    idle(2);

    // Back-to-back transfer, then re-arm in the cycle done is high
    step(1'b1, 12'h010, 13'd4, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, rw());
    step(1'b1, 12'h010, 13'd4, 1'b0, '0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, '0, pat[i], rw());
    idle(2);

    // Address wrap
    step(1'b1, 12'hFFE, 13'd4, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, rw());
    idle(2);

    // Zero-length transfer
    step(1'b1, 12'h123, 13'd0, 1'b0, '0);
    idle(3);

    // Unexpected words, clearing, and same-cycle set/arm
    step(1'b0, '0, '0, 1'b1, rw());
    step(1'b0, '0, '0, 1'b1, rw());
    idle(1);
    step(1'b1, 12'h200, 13'd2, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, rw());
    step(1'b0, '0, '0, 1'b1, rw());
    step(1'b0, '0, '0, 1'b1, rw());
    idle(1);
    step(1'b1, 12'h300, 13'd2, 1'b1, rw());
    step(1'b0, '0, '0, 1'b1, rw());
    step(1'b0, '0, '0, 1'b1, rw());
    idle(2);

    // Reset mid-transfer, stray word after, ignored cfg_start while armed
    step(1'b1, 12'h040, 13'd8, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, rw());
    step(1'b0, '0, '0, 1'b1, rw());
    do_reset();
    step(1'b0, '0, '0, 1'b1, rw());
    idle(1);
    step(1'b1, 12'h050, 13'd3, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, rw());
    step(1'b1, 12'h777, 13'd5, 1'b1, rw());
    step(1'b0, '0, '0, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, rw());
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 6) == 0, AW'($urandom), LW'($urandom % 7),
           ($urandom % 3) != 0, rw());
    end
    idle(4);

    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
